accum4_seq: RTL and testbench



---
 rtl/accum_pkg.sv | 22 ++
 rtl/full_adder.sv | 16 +
 rtl/ripple_adder_n.sv | 30 +++
 rtl/accum4_seq.sv | 119 +++++++++++
 tb/tb_accum4_seq.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accum_pkg.sv
// Shared types and constants for the accum4_seq accumulator slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: frame FSM state enum, beat-counter width helper, saturation constant.
package accum_pkg;

  // ACC collects beats, HOLD presents the frame result until it is taken.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // The beat counter must be able to hold COUNT itself, not just COUNT-1.
  function automatic int cnt_width(input int count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

  // All-ones saturation value. Kept at 64 bits so any operand width up to
  // 64 can slice its own all-ones value from it.
  localparam logic [63:0] SAT_VAL = '1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the cell the ripple adder chains together.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, cin -> sum, cout.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder_n.sv
// WIDTH-bit unsigned ripple-carry adder built from full_adder cells, carry-in tied to 0.
// Latency: combinational (WIDTH carry stages).
// Backpressure: none.
// Ports: a, b (WIDTH) -> sum (WIDTH), cout (carry out of the MSB).
module ripple_adder_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/accum4_seq.sv
// Frame accumulator: sums up to COUNT operand beats per frame through a ripple adder.
// Latency: out_valid rises the cycle after the closing beat is accepted; N-beat frame takes N+1 cycles.
// Backpressure: in_ready drops while a result waits in HOLD; the result is held until out_ready.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data/in_last operand stream;
//        out_valid/out_ready/out_sum/out_overflow/out_count result stream.
// Build option: define ACCUM_SATURATE_EN to clamp the accumulator at all-ones on carry
//               instead of wrapping modulo 2^WIDTH.
module accum4_seq
  import accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int COUNT = 4,
  parameter int CNT_W = cnt_width(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf;
  logic             accept;
  logic             close;
  logic             drain;

  ripple_adder_n #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (acc),
    .b    (in_data),
    .sum  (add_sum),
    .cout (carry)
  );

`ifdef ACCUM_SATURATE_EN
  // A saturated accumulator plus any non-zero operand carries again, so it
  // stays pinned at all-ones for the rest of the frame.
  assign acc_nxt = carry ? SAT_VAL[WIDTH-1:0] : add_sum;
`else
  assign acc_nxt = add_sum;
`endif

  assign cnt_inc = cnt + CNT_W'(1);
  assign accept  = in_valid & in_ready;
  // The beat that fills the frame or carries in_last closes it.
  assign close   = accept & ((cnt == CNT_W'(COUNT - 1)) | in_last);
  assign drain   = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (close) state_nxt = HOLD;
      HOLD:    if (drain) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
      out_count    <= '0;
    end else begin
      // Handshake flags follow the next state, so in_ready comes up on the
      // first edge after reset release and both are glitch-free registers.
      in_ready  <= (state_nxt == ACC);
      out_valid <= (state_nxt == HOLD);

      if (accept) begin
        acc <= acc_nxt;
        ovf <= ovf | carry;
        cnt <= cnt_inc;
      end

      if (close) begin
        out_sum      <= acc_nxt;
        out_overflow <= ovf | carry;
        out_count    <= cnt_inc;
      end

      // Result consumed: start the next frame from zero. out_* keep their
      // values until the next frame closes.
      if (state == HOLD && drain) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accum4_seq.sv
// Self-checking bench for accum4_seq (WIDTH=4, COUNT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_accum4_seq;

  localparam int WIDTH = 4;
  localparam int COUNT = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_overflow;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accum4_seq #(
    .WIDTH (WIDTH),
    .COUNT (COUNT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  // Sends one frame (beat i in beats[4*i+:4]), checks the result against an
  // integer model of the frame, then releases it unless keep_result is set.
  task automatic run_frame(input logic [15:0] beats, input int n, input bit last_on_n,
                           input int ready_delay, input int max_gap, input bit keep_result,
                           input string name);
    int acc;
    int t;
    int guard;
    bit ovf;
    logic [3:0] exp_sum;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = acc + int'(beats[4*i +: 4]);
      if (t > 15) begin
        ovf = 1'b1;
`ifdef ACCUM_SATURATE_EN
        acc = 15;
`else
        acc = t - 16;
`endif
      end else begin
        acc = t;
      end
    end
    exp_sum = acc[3:0];

    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = beats[4*i +: 4];
      in_last  = (i == n - 1) && last_on_n;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s beat %0d in_ready: got %b, required 1", name, i, in_ready);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s out_valid latency: got %b, required 1", name, out_valid);
    end
    n_cmp++;
    if (out_sum !== exp_sum) begin
      n_err++;
      $display("FAIL %s out_sum: got %b, required %b", name, out_sum, exp_sum);
    end
    n_cmp++;
    if (out_overflow !== ovf) begin
      n_err++;
      $display("FAIL %s out_overflow: got %b, required %b", name, out_overflow, ovf);
    end
    n_cmp++;
    if (out_count !== CNT_W'(n)) begin
      n_err++;
      $display("FAIL %s out_count: got %0d, required %0d", name, out_count, n);
    end
    if (keep_result) return;

    repeat (ready_delay) @(negedge clk);
    if (ready_delay > 0) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_sum !== exp_sum) begin
        n_err++;
        $display("FAIL %s held result: got valid=%b sum=%b, required valid=1 sum=%b",
                 name, out_valid, out_sum, exp_sum);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b, required 0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_sum, out_overflow, out_count} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got rdy=%b vld=%b sum=%b ovf=%b cnt=%0d, required all 0",
               in_ready, out_valid, out_sum, out_overflow, out_count);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset in_ready before edge: got %b, required 0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset first edge: got in_ready=%b out_valid=%b, required 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    run_frame(16'h4321, 4, 1'b0, 0, 0, 1'b0, "plain_4");
    run_frame(16'h012F, 4, 1'b0, 1, 0, 1'b0, "wrap_4");
    run_frame(16'h0035, 2, 1'b1, 0, 0, 1'b0, "early_last_2");
    run_frame(16'h0001, 1, 1'b1, 0, 0, 1'b0, "fresh_after_last");
    run_frame(16'h0009, 1, 1'b1, 2, 0, 1'b0, "last_first_beat");
  endtask

  task automatic test_hold;
    run_frame(16'h2143, 4, 1'b0, 0, 0, 1'b1, "hold_frame");
    in_valid = 1'b1;
    in_data  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 4'b1010 ||
          out_overflow !== 1'b0 || out_count !== 3'd4) begin
        n_err++;
        $display("FAIL hold cycle %0d: got rdy=%b vld=%b sum=%b ovf=%b cnt=%0d, required 0 1 1010 0 4",
                 i, in_ready, out_valid, out_sum, out_overflow, out_count);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold release: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    // A single beat after the release shows acc restarted at zero.
    run_frame(16'h0001, 1, 1'b1, 0, 0, 1'b0, "after_hold");
  endtask

  task automatic test_mid_reset;
    in_valid = 1'b1;
    in_data  = 4'b0111;
    in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_sum, out_overflow, out_count} !== '0) begin
      n_err++;
      $display("FAIL mid_reset outputs: got rdy=%b vld=%b sum=%b ovf=%b cnt=%0d, required all 0",
               in_ready, out_valid, out_sum, out_overflow, out_count);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_frame(16'h3333, 4, 1'b0, 0, 0, 1'b0, "after_mid_reset");
  endtask

  task automatic test_back_to_back;
    int cyc;
    int pulses;
    int prev;
    cyc = 0;
    pulses = 0;
    prev = 0;
    in_valid  = 1'b1;
    in_data   = 4'b0001;
    in_last   = 1'b0;
    out_ready = 1'b1;
    while (pulses < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        pulses++;
        if (pulses == 3) in_valid = 1'b0;
        n_cmp++;
        if (out_sum !== 4'b0100 || out_count !== 3'd4 || out_overflow !== 1'b0) begin
          n_err++;
          $display("FAIL b2b frame %0d: got sum=%b cnt=%0d ovf=%b, required 0100 4 0",
                   pulses, out_sum, out_count, out_overflow);
        end
        if (pulses > 1) begin
          n_cmp++;
          if (cyc - prev != 5) begin
            n_err++;
            $display("FAIL b2b spacing: got %0d cycles, required 5", cyc - prev);
          end
        end
        prev = cyc;
      end
    end
    n_cmp++;
    if (pulses != 3) begin
      n_err++;
      $display("FAIL b2b pulse count: got %0d, required 3", pulses);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic test_random;
    int n;
    bit lst;
    for (int f = 0; f < 25; f++) begin
      n   = $urandom_range(1, COUNT);
      lst = (n < COUNT) ? 1'b1 : 1'(($urandom_range(0, 1)));
      run_frame(16'($urandom), n, lst, $urandom_range(0, 3), 2, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
